johnson_seq_decoder: RTL and testbench
======================================

// Module: johnson_seq_decoder
// PURPOSE
//  Receive-side companion to the team's right-shifting Johnson counter. Samples a
//  WIDTH-bit Johnson-coded bus, decodes it to a binary index and a one-hot vector,
//  flags illegal codes and sequence breaks, and tracks lock to the running count.
//  Sits at the consumer end of any Johnson-coded count/phase bus.
// PARAMETERS
//  WIDTH     4  Johnson code width; 2*WIDTH legal states.
//  LOCK_CNT  3  consecutive correct +1 steps required to assert locked.
//  ERR_W     8  width of saturating error counter.
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 asynchronous, active-high reset
//  din        in   WIDTH             Johnson-coded sample
//  din_valid  in   1                 din is sampled on this edge
//  err_clr    in   1                 synchronous clear of err_cnt
//  idx        out  $clog2(2*WIDTH)   decoded index of last legal sample
//  idx_valid  out  1                 1-cycle pulse: idx updated from a legal sample
//  onehot     out  2*WIDTH           onehot[idx]; all-zero when idx_valid=0
//  code_err   out  1                 1-cycle pulse: sampled din was not a legal code
//  seq_err    out  1                 1-cycle pulse: legal code but not prev+1 while locked
//  locked     out  1                 level: tracking a continuous count
//  err_cnt    out  ERR_W             saturating count of code_err+seq_err pulses
// BEHAVIOUR
//  Clock/reset: one clock clk; rst asynchronous, active-high.
//  - Reset: all outputs 0, FSM=ACQ, run=0, have_prev=0, prev_idx=0.
//  - Code map (WIDTH=4; sequence follows {~d[0],d[W-1:1]}):
//    0000=0 1000=1 1100=2 1110=3 1111=4 0111=5 0011=6 0001=7. k=popcount(din):
//    idx=k if din[W-1]=1 or din=0, else 2W-k. Legal iff encode(idx)==din.
//  - Latency: all outputs registered; one cycle after the sampling edge.
//  - din_valid=0: pulses deassert, onehot=0; idx, locked, FSM, run, prev held.
//  - Step ok: idx == (prev_idx+1) mod 2W; wrap 2W-1 -> 0 is legal. A repeated
//    code (idx==prev_idx) is a step error.
//  - FSM ACQ:
//    illegal -> code_err=1, have_prev=0, run=0.
//    legal, have_prev and step ok -> run++; run reaches LOCK_CNT -> LOCKED, locked=1.
//    legal otherwise -> run=0, no seq_err (sample becomes the new reference).
//  - FSM LOCKED:
//    legal and step ok -> stay.
//    illegal -> code_err=1, locked=0, ACQ, have_prev=0, run=0.
//    legal, bad step -> seq_err=1, locked=0, ACQ, run=0, sample becomes reference.
//  - Every legal sample: prev_idx=idx, have_prev=1, idx_valid=1, onehot=1<<idx.
//  - Illegal sample: idx and prev_idx hold; idx_valid=0.
//  - err_cnt: +1 per code_err or seq_err; saturates at 2^ERR_W-1.
//    err_clr same cycle as an error: clear wins, err_cnt=0.
//  - rst mid-operation: immediate return to reset values; relock needs 1 reference
//    sample plus LOCK_CNT steps.
// STRUCTURE
//  - johnson_pkg: fsm state enum {ACQ,LOCKED}; functions jc_decode(code)->idx and
//    jc_encode(idx)->code; IDX_W = $clog2(2*WIDTH) derivation.
//  - Sub-module johnson_code_decode: combinational din -> {idx, legal}.
//    Parent holds FSM, run counter, prev_idx, err_cnt and output registers.
// TESTING
//  1 Reset then din=0001,0000,1000,1100 (valid each cycle) -> idx 7,0,1,2; locked=1
//    one cycle after the 1100 sample; no errors.
//  2 Locked, count through 0001 -> 0000 -> idx 7 then 0; locked stays 1, no seq_err.
//  3 Locked at 1000, next din=1110 -> seq_err pulse, locked=0, err_cnt=1; then
//    1111,0111,0011 -> relocks.
//  4 din=0101 -> code_err pulse, idx_valid=0, idx holds; err_cnt increments.
//  5 Force 300 errors with ERR_W=8 -> err_cnt stops at 255; err_clr plus an error
//    in the same cycle -> err_cnt=0.
//  6 Locked, din_valid low 5 cycles, then correct next code -> locked held, no error;
//    rst pulse mid-stream -> all outputs 0 asynchronously, FSM back in ACQ.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code receive path.
package johnson_pkg;

    // Widest Johnson code the helper functions can handle.
    localparam int MAX_W = 64;

    typedef enum logic {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } jc_state_t;

    // Index width for a WIDTH-bit code with 2*WIDTH states.
    function automatic int jc_idx_w(input int w);
        return $clog2(2 * w);
    endfunction

    // Popcount-based decode: idx = k when the MSB is set or the code is all
    // zero, otherwise 2W-k. Legality is checked separately against jc_encode.
    function automatic int jc_decode(input logic [MAX_W-1:0] code, input int w);
        int  k;
        logic top;
        k   = 0;
        top = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (((code >> i) & MAX_W'(1)) != '0) begin
                    k++;
                    if (i == w - 1) top = 1'b1;
                end
            end
        end
        if (top || (k == 0)) return k;
        return 2 * w - k;
    endfunction

    // Canonical code for a state index of the right-shifting Johnson counter:
    // states 0..W fill ones from the MSB down, W+1..2W-1 drain them from the top.
    function automatic logic [MAX_W-1:0] jc_encode(input int idx, input int w);
        logic [MAX_W-1:0] code;
        code = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if ((idx <= w) ? (i >= w - idx) : (i < 2 * w - idx))
                    code = code | (MAX_W'(1) << i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code decoder: din -> {idx, legal}.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = jc_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    output logic [IDX_W-1:0] idx,
    output logic             legal
);

    localparam int N = 2 * WIDTH;

    logic [N-1:0] match;

    // One comparator per legal state; a code is legal only if it equals one.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_state
            localparam logic [WIDTH-1:0] ENC = WIDTH'(jc_encode(gi, WIDTH));
            assign match[gi] = (din == ENC);
        end
    endgenerate

    assign legal = |match;
    assign idx   = IDX_W'(jc_decode(MAX_W'(din), WIDTH));

endmodule

// File: rtl/johnson_seq_decoder.sv
// Johnson-coded bus receiver: decode, sequence tracking, lock and error count.
module johnson_seq_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = jc_idx_w(WIDTH),
    localparam int N       = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic [N-1:0]     onehot,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    logic [IDX_W-1:0] dec_idx;
    logic             dec_legal;

    jc_state_t        state_reg, state_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             have_prev_reg, have_prev_next;
    logic [IDX_W-1:0] prev_reg, prev_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             idx_valid_reg, idx_valid_next;
    logic [N-1:0]     onehot_reg, onehot_next;
    logic             code_err_reg, code_err_next;
    logic             seq_err_reg, seq_err_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

    logic [IDX_W-1:0] expect_idx;
    logic             step_ok;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .din   (din),
        .idx   (dec_idx),
        .legal (dec_legal)
    );

    // Successor of the reference index, wrapping 2W-1 -> 0.
    assign expect_idx = (prev_reg == IDX_W'(N - 1)) ? '0 : prev_reg + 1'b1;
    assign step_ok    = have_prev_reg && (dec_idx == expect_idx);

    // One-hot of the decoded index, only for a valid legal sample.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot_next[gi] = din_valid && dec_legal && (dec_idx == IDX_W'(gi));
        end
    endgenerate

    // Next-state: acquisition/lock FSM, reference tracking and pulse outputs.
    always_comb begin
        state_next     = state_reg;
        run_next       = run_reg;
        have_prev_next = have_prev_reg;
        prev_next      = prev_reg;
        idx_next       = idx_reg;
        idx_valid_next = 1'b0;
        code_err_next  = 1'b0;
        seq_err_next   = 1'b0;
        if (din_valid) begin
            if (!dec_legal) begin
                code_err_next  = 1'b1;
                have_prev_next = 1'b0;
                run_next       = '0;
                state_next     = ACQ;
            end else begin
                prev_next      = dec_idx;
                have_prev_next = 1'b1;
                idx_next       = dec_idx;
                idx_valid_next = 1'b1;
                case (state_reg)
                    ACQ: begin
                        if (step_ok) begin
                            if (run_reg == RUN_W'(LOCK_CNT - 1)) begin
                                state_next = LOCKED;
                                run_next   = '0;
                            end else begin
                                run_next = run_reg + 1'b1;
                            end
                        end else begin
                            run_next = '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_ok) begin
                            seq_err_next = 1'b1;
                            state_next   = ACQ;
                            run_next     = '0;
                        end
                    end
                    default: state_next = ACQ;
                endcase
            end
        end
    end

    // Saturating error counter; a clear overrides a same-cycle error.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_clr)
            err_cnt_next = '0;
        else if ((code_err_next || seq_err_next) && (err_cnt_reg != '1))
            err_cnt_next = err_cnt_reg + 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ACQ;
            run_reg       <= '0;
            have_prev_reg <= 1'b0;
            prev_reg      <= '0;
            idx_reg       <= '0;
            idx_valid_reg <= 1'b0;
            onehot_reg    <= '0;
            code_err_reg  <= 1'b0;
            seq_err_reg   <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            have_prev_reg <= have_prev_next;
            prev_reg      <= prev_next;
            idx_reg       <= idx_next;
            idx_valid_reg <= idx_valid_next;
            onehot_reg    <= onehot_next;
            code_err_reg  <= code_err_next;
            seq_err_reg   <= seq_err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign idx       = idx_reg;
    assign idx_valid = idx_valid_reg;
    assign onehot    = onehot_reg;
    assign code_err  = code_err_reg;
    assign seq_err   = seq_err_reg;
    assign locked    = (state_reg == LOCKED);
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// Scoreboard bench for johnson_seq_decoder (WIDTH=4, LOCK_CNT=3, ERR_W=8).
module tb_johnson_seq_decoder;

    localparam int W        = 4;
    localparam int NS       = 2 * W;
    localparam int LOCK_CNT = 3;
    localparam int ERR_MAX  = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         err_clr = 1'b0;
    logic [2:0]   idx;
    logic         idx_valid;
    logic [7:0]   onehot;
    logic         code_err;
    logic         seq_err;
    logic         locked;
    logic [7:0]   err_cnt;

    typedef struct packed {
        logic [2:0] idx;
        logic       idx_valid;
        logic [7:0] onehot;
        logic       code_err;
        logic       seq_err;
        logic       locked;
        logic [7:0] err_cnt;
    } exp_t;

    exp_t q[$];
    exp_t m_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] tab[NS];
    int m_prev, m_run, m_err, m_idx;
    bit m_locked;

    johnson_seq_decoder #(.WIDTH(W), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .idx       (idx),
        .idx_valid (idx_valid),
        .onehot    (onehot),
        .code_err  (code_err),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lookup(input logic [W-1:0] d);
        for (int i = 0; i < NS; i++)
            if (tab[i] == d) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev   = -1;
        m_run    = 0;
        m_err    = 0;
        m_idx    = 0;
        m_locked = 0;
    endtask

    // Behavioural model of one sampling edge, from the decoder's rules.
    task automatic model_step(input bit r, input bit v, input logic [W-1:0] d, input bit c);
        int  i;
        bit  ok;
        bit  ce, se;
        m_out = '0;
        ce = 0;
        se = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (v) begin
            i = lookup(d);
            if (i < 0) begin
                ce       = 1;
                m_locked = 0;
                m_prev   = -1;
                m_run    = 0;
            end else begin
                ok = (m_prev >= 0) && (i == (m_prev + 1) % NS);
                if (m_locked) begin
                    if (!ok) begin
                        se       = 1;
                        m_locked = 0;
                        m_run    = 0;
                    end
                end else if (ok) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_prev          = i;
                m_idx           = i;
                m_out.idx_valid = 1'b1;
                m_out.onehot    = 8'(1) << i;
            end
        end
        if (c) m_err = 0;
        else if ((ce || se) && m_err < ERR_MAX) m_err++;
        m_out.code_err = ce;
        m_out.seq_err  = se;
        m_out.idx      = 3'(m_idx);
        m_out.locked   = m_locked;
        m_out.err_cnt  = 8'(m_err);
    endtask

    // Apply one cycle of stimulus and queue the response it should produce.
    task automatic drive(input bit r, input bit v, input logic [W-1:0] d, input bit c);
        @(negedge clk);
        rst       = r;
        din_valid = v;
        din       = d;
        err_clr   = c;
        if (r) begin
            #1;
            chk("async_rst_outputs",
                int'({idx, idx_valid, onehot, code_err, seq_err, locked, err_cnt}), 0);
        end
        model_step(r, v, d, c);
        q.push_back(m_out);
    endtask

    task automatic send(input logic [W-1:0] d);
        drive(0, 1, d, 0);
    endtask

    // Monitor: compare each registered response against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("idx",       int'(idx),       int'(e.idx));
                chk("idx_valid", int'(idx_valid), int'(e.idx_valid));
                chk("onehot",    int'(onehot),    int'(e.onehot));
                chk("code_err",  int'(code_err),  int'(e.code_err));
                chk("seq_err",   int'(seq_err),   int'(e.seq_err));
                chk("locked",    int'(locked),    int'(e.locked));
                chk("err_cnt",   int'(err_cnt),   int'(e.err_cnt));
                $display("t=%0t idx=%0d v=%0b oh=%b ce=%0b se=%0b lk=%0b ec=%0d",
                         $time, idx, idx_valid, onehot, code_err, seq_err, locked, err_cnt);
            end
        end
    end

    initial begin
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < NS; i++) begin
            tab[i] = c;
            c = {~c[0], c[W-1:1]};
        end
        model_reset();

        #3;
        chk("reset_outputs",
            int'({idx, idx_valid, onehot, code_err, seq_err, locked, err_cnt}), 0);
        drive(0, 0, '0, 0);

        // Acquire and lock across the wrap
        send(4'b0001); send(4'b0000); send(4'b1000); send(4'b1100);
        // Count through a full turn including 0001 -> 0000
        send(4'b1110); send(4'b1111); send(4'b0111); send(4'b0011);
        send(4'b0001); send(4'b0000); send(4'b1000);
        // Sequence break then relock
        send(4'b1110); send(4'b1111); send(4'b0111); send(4'b0011);
        // Illegal code
        send(4'b0101);
        // Relock, idle gap, continue
        send(4'b0001); send(4'b0000); send(4'b1000); send(4'b1100);
        for (int i = 0; i < 5; i++) drive(0, 0, 4'b1010, 0);
        send(4'b1110);
        // Reset mid-stream
        drive(1, 1, 4'b1111, 0);
        drive(1, 1, 4'b0111, 0);
        send(4'b0111);
        send(4'b0011);
        // Error counter saturation, then clear with a same-cycle error
        for (int i = 0; i < 300; i++) send(4'b0101);
        drive(0, 1, 4'b0101, 1);
        send(4'b1001);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            bit r, v, cl;
            int sel;
            logic [W-1:0] d;
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) != 0);
            cl  = ($urandom_range(0, 49) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)
                d = (m_prev >= 0) ? tab[(m_prev + 1) % NS] : tab[$urandom_range(0, NS - 1)];
            else if (sel == 7)
                d = tab[$urandom_range(0, NS - 1)];
            else
                d = W'($urandom_range(0, 15));
            drive(r, v, d, cl);
        end
        drive(0, 0, '0, 0);

        repeat (3) @(posedge clk);
        #5;
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
